// File: rtl/conv1d_stream_engine.sv
// Streaming 1-D convolution of one pixel row with a KSIZE-tap signed kernel.
// Two-stage pipeline (tap products, then adder tree) with valid/ready output and global stall.
module conv1d_stream_engine #(
  parameter int N_PIX = 32,
  parameter int KSIZE = 3,
  parameter int PIX_W = 8,
  parameter int W_W   = 8,
  localparam int ACC_W = PIX_W + W_W + $clog2(KSIZE),
  localparam int IDX_W = $clog2(N_PIX)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    pad_mode,
  input  logic                    relu_en,
  input  logic [N_PIX*PIX_W-1:0]  pixel_row_data,
  input  logic [KSIZE*W_W-1:0]    kernel_data,
  output logic                    busy,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] out_data,
  output logic [IDX_W-1:0]        out_index,
  output logic                    out_last,
  output logic                    done_signal
);

  localparam int CNT_W  = IDX_W + 1;
  localparam int PROD_W = PIX_W + W_W + 1;
  localparam int HALF   = (KSIZE - 1) / 2;
  localparam logic [CNT_W-1:0] M_VALID = CNT_W'(N_PIX - KSIZE + 1);
  localparam logic [CNT_W-1:0] M_SAME  = CNT_W'(N_PIX);

  if ((KSIZE % 2) == 0 || KSIZE < 3 || KSIZE > 7 || KSIZE > N_PIX) begin : g_bad_params
    $error("conv1d_stream_engine: KSIZE must be odd, 3..7 and <= N_PIX");
  end

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t                          state_reg, state_next;
  logic [N_PIX*PIX_W-1:0]          row_reg;
  logic [KSIZE*W_W-1:0]            kern_reg;
  logic                            pad_reg, relu_reg;
  logic [CNT_W-1:0]                issue_cnt_reg;
  logic [CNT_W-1:0]                m_count;
  logic                            s1_valid_reg, s1_last_reg;
  logic [IDX_W-1:0]                s1_idx_reg;
  logic [KSIZE-1:0][PROD_W-1:0]    prod_next, prod_reg;
  logic signed [ACC_W-1:0]         acc;
  logic                            out_valid_reg, out_last_reg;
  logic signed [ACC_W-1:0]         out_data_reg;
  logic [IDX_W-1:0]                out_index_reg;
  logic                            advance, issue_en, capture;
  int                              shift;

  assign capture  = (state_reg == IDLE) && start;
  assign m_count  = pad_reg ? M_SAME : M_VALID;
  // Every stage moves together; a held result freezes the whole pipe.
  assign advance  = !out_valid_reg || out_ready;
  assign issue_en = (state_reg == RUN) && (issue_cnt_reg < m_count);

  always_comb begin
    shift = 0;
    if (pad_reg) shift = HALF;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next  = state_reg;
    busy        = 1'b0;
    done_signal = 1'b0;
    case (state_reg)
      IDLE: if (start) state_next = LOAD;
      LOAD: begin
        busy       = 1'b1;
        state_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (out_valid_reg && out_ready && out_last_reg) state_next = DONE;
      end
      DONE: begin
        busy        = 1'b1;
        done_signal = 1'b1;
        state_next  = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_reg  <= '0;
      kern_reg <= '0;
      pad_reg  <= 1'b0;
      relu_reg <= 1'b0;
    end else if (capture) begin
      row_reg  <= pixel_row_data;
      kern_reg <= kernel_data;
      pad_reg  <= pad_mode;
      relu_reg <= relu_en;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    issue_cnt_reg <= '0;
    else if (capture)              issue_cnt_reg <= '0;
    else if (issue_en && advance)  issue_cnt_reg <= issue_cnt_reg + CNT_W'(1);
  end

  genvar gi;
  for (gi = 0; gi < KSIZE; gi++) begin : g_tap
    logic [PIX_W-1:0]         tap_pix;
    logic signed [PROD_W-1:0] w_ext, p_ext;

    // Position j+gi-shift; anything outside the row never matches and reads as zero.
    always_comb begin
      tap_pix = '0;
      for (int i = 0; i < N_PIX; i++) begin
        if (i + shift == int'(issue_cnt_reg) + gi) tap_pix = row_reg[i*PIX_W +: PIX_W];
      end
    end

    assign w_ext         = PROD_W'(signed'(kern_reg[gi*W_W +: W_W]));
    assign p_ext         = {{(W_W + 1){1'b0}}, tap_pix};
    assign prod_next[gi] = w_ext * p_ext;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      s1_idx_reg   <= '0;
      s1_last_reg  <= 1'b0;
      prod_reg     <= '0;
    end else if (advance) begin
      s1_valid_reg <= issue_en;
      s1_idx_reg   <= issue_cnt_reg[IDX_W-1:0];
      s1_last_reg  <= (issue_cnt_reg == m_count - CNT_W'(1));
      prod_reg     <= prod_next;
    end
  end

  always_comb begin
    acc = '0;
    for (int k = 0; k < KSIZE; k++) acc = acc + ACC_W'($signed(prod_reg[k]));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
      out_data_reg  <= '0;
      out_index_reg <= '0;
    end else if (advance) begin
      out_valid_reg <= s1_valid_reg;
      out_last_reg  <= s1_valid_reg && s1_last_reg;
      if (s1_valid_reg) begin
        out_data_reg  <= (relu_reg && acc[ACC_W-1]) ? '0 : acc;
        out_index_reg <= s1_idx_reg;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign out_last  = out_last_reg;
  assign out_data  = out_data_reg;
  assign out_index = out_index_reg;

endmodule

// File: tb/tb_conv1d_stream_engine.sv
// Directed bench for conv1d_stream_engine at default parameters.
// Each row is driven, collected, and compared against hand values and a reference sum.
module tb_conv1d_stream_engine;

  logic               clk;
  logic               rst_n;
  logic               start;
  logic               pad_mode;
  logic               relu_en;
  logic [255:0]       pixel_row_data;
  logic [23:0]        kernel_data;
  logic               busy;
  logic               out_valid;
  logic               out_ready;
  logic signed [17:0] out_data;
  logic [4:0]         out_index;
  logic               out_last;
  logic               done_signal;

  int     checks = 0;
  int     errors = 0;
  int     pix [32];
  int     kw  [3];
  longint obs [32];

  conv1d_stream_engine dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .pad_mode       (pad_mode),
    .relu_en        (relu_en),
    .pixel_row_data (pixel_row_data),
    .kernel_data    (kernel_data),
    .busy           (busy),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_index      (out_index),
    .out_last       (out_last),
    .done_signal    (done_signal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input longint observed, input longint expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Packs the row/kernel, pulses start across edge T, then scrambles the inputs.
  task automatic start_row(input bit pad, input bit relu);
    for (int i = 0; i < 32; i++) pixel_row_data[i*8 +: 8] = 8'(pix[i]);
    for (int k = 0; k < 3; k++)  kernel_data[k*8 +: 8]    = 8'(kw[k]);
    for (int i = 0; i < 32; i++) obs[i] = -999999;
    pad_mode  = pad;
    relu_en   = relu;
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start          = 1'b0;
    pixel_row_data = {32{8'hA5}};
    kernel_data    = '0;
    pad_mode       = ~pad;
    relu_en        = ~relu;
  endtask

  task automatic run_row(input string name, input bit pad, input bit relu, input bit bp,
                         input int exp_done);
    int     m, off, got, first_v, done_at, done_cnt, hold_cnt, n;
    longint expv [32];
    longint s;
    bit     prev_stall, sv_last;
    longint sv_data;
    int     sv_idx;
    m   = pad ? 32 : 30;
    off = pad ? 1 : 0;
    for (int j = 0; j < 32; j++) begin
      s = 0;
      for (int k = 0; k < 3; k++) begin
        if (j + k - off >= 0 && j + k - off < 32) s += longint'(kw[k]) * longint'(pix[j + k - off]);
      end
      if (relu && s < 0) s = 0;
      expv[j] = s;
    end
    start_row(pad, relu);
    got = 0; first_v = -1; done_at = -1; done_cnt = 0; hold_cnt = 0; n = 0;
    prev_stall = 1'b0; sv_data = 0; sv_idx = 0; sv_last = 1'b0;
    while (n < 400 && !(done_at >= 0 && n > done_at + 2)) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 1) check({name, " busy_load"}, busy, 1);
      if (prev_stall) begin
        check({name, " hold_data"}, out_data, sv_data);
        check({name, " hold_index"}, out_index, sv_idx);
        check({name, " hold_last"}, out_last, sv_last);
      end
      if (out_valid && first_v < 0) first_v = n;
      if (done_signal) begin
        done_cnt++;
        if (done_at < 0) done_at = n;
      end
      if (bp) begin
        if (out_valid && out_index == 5'd3 && hold_cnt < 5) begin
          out_ready = 1'b0;
          hold_cnt++;
        end else begin
          out_ready = 1'($urandom_range(0, 1));
        end
        start = (n == 10);
      end
      if (out_valid && out_ready) begin
        check({name, " index"}, out_index, got);
        if (got < 32) begin
          check({name, " data"}, out_data, expv[got]);
          obs[got] = out_data;
        end
        check({name, " last"}, out_last, (got == m - 1));
        got++;
      end
      prev_stall = out_valid && !out_ready;
      sv_data    = out_data;
      sv_idx     = out_index;
      sv_last    = out_last;
    end
    out_ready = 1'b1;
    start     = 1'b0;
    check({name, " first_valid_cycle"}, first_v, 3);
    check({name, " result_count"}, got, m);
    check({name, " done_pulses"}, done_cnt, 1);
    if (exp_done >= 0) check({name, " done_cycle"}, done_at, exp_done);
    check({name, " idle_after"}, busy, 0);
    if (bp) check({name, " stall_cycles"}, hold_cnt, 5);
    $display("row %s: %0d results, first valid T+%0d, done T+%0d", name, got, first_v, done_at);
  endtask

  initial begin
    int found;
    rst_n = 1'b0; start = 1'b0; pad_mode = 1'b0; relu_en = 1'b0; out_ready = 1'b1;
    pixel_row_data = '0; kernel_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", busy, 0);
    check("reset out_valid", out_valid, 0);
    check("reset out_data", out_data, 0);
    check("reset out_index", out_index, 0);
    check("reset out_last", out_last, 0);
    check("reset done", done_signal, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Ramp row with a second-difference kernel.
    for (int i = 0; i < 32; i++) pix[i] = i;
    kw[0] = -1; kw[1] = 2; kw[2] = -1;
    run_row("ramp_valid", 0, 0, 0, 33);
    check("ramp_valid out0", obs[0], 0);
    check("ramp_valid out29", obs[29], 0);
    run_row("ramp_same", 1, 0, 0, 35);
    check("ramp_same out0", obs[0], -1);
    check("ramp_same out1", obs[1], 0);
    check("ramp_same out30", obs[30], 0);
    check("ramp_same out31", obs[31], 32);

    // Single impulse.
    for (int i = 0; i < 32; i++) pix[i] = 0;
    pix[10] = 255;
    kw[0] = 3; kw[1] = -5; kw[2] = 7;
    run_row("impulse", 0, 0, 0, 33);
    check("impulse out7", obs[7], 0);
    check("impulse out8", obs[8], 1785);
    check("impulse out9", obs[9], -1275);
    check("impulse out10", obs[10], 765);
    check("impulse out11", obs[11], 0);
    run_row("impulse_relu", 0, 1, 0, 33);
    check("impulse_relu out8", obs[8], 1785);
    check("impulse_relu out9", obs[9], 0);
    check("impulse_relu out10", obs[10], 765);

    // Extreme magnitude: no wrap in the accumulator.
    for (int i = 0; i < 32; i++) pix[i] = 255;
    kw[0] = -128; kw[1] = -128; kw[2] = -128;
    run_row("extreme", 0, 0, 0, 33);
    check("extreme out0", obs[0], -97920);
    check("extreme out29", obs[29], -97920);
    run_row("extreme_relu", 0, 1, 0, 33);
    check("extreme_relu out0", obs[0], 0);
    check("extreme_relu out29", obs[29], 0);

    // Backpressure with a distinct value per index: out[j] = 6j+8.
    for (int i = 0; i < 32; i++) pix[i] = i;
    kw[0] = 1; kw[1] = 2; kw[2] = 3;
    run_row("backpressure", 0, 0, 1, -1);
    check("backpressure out3", obs[3], 26);
    check("backpressure out29", obs[29], 182);

    // Asynchronous reset while index 12 is presented.
    start_row(0, 0);
    found = 0;
    for (int c = 0; c < 100 && found == 0; c++) begin
      @(posedge clk);
      #1;
      if (out_valid && out_index == 5'd12) found = 1;
    end
    check("mid_reset reached index12", found, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_reset out_valid", out_valid, 0);
    check("mid_reset busy", busy, 0);
    check("mid_reset done", done_signal, 0);
    check("mid_reset out_index", out_index, 0);
    repeat (2) @(posedge clk);
    #1;
    check("mid_reset done held", done_signal, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_row("after_reset", 0, 0, 0, 33);
    check("after_reset out0", obs[0], 8);
    check("after_reset out12", obs[12], 80);
    check("after_reset out29", obs[29], 182);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv1d_stream_engine.md
CONV1D_STREAM_ENGINE -- requirements
Module: conv1d_stream_engine

Interface
REQ-001 Parameters SHALL be: N_PIX (default 32) = pixels per row; KSIZE (default 3) = taps, odd, 3..7, KSIZE <= N_PIX; PIX_W (default 8) = unsigned pixel width; W_W (default 8) = signed weight width; ACC_W = PIX_W+W_W+$clog2(KSIZE) (18 at defaults), derived and not overridable.
REQ-002 Ports SHALL be, clock and reset first:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  begin one row, sampled only in IDLE
- pad_mode  in  1  0 = VALID, 1 = SAME with zero padding; latched at start
- relu_en  in  1  clamp negative results to 0; latched at start
- pixel_row_data  in  N_PIX*PIX_W  pixel i at bits [i*PIX_W +: PIX_W]; latched at start
- kernel_data  in  KSIZE*W_W  signed tap k at bits [k*W_W +: W_W]; latched at start
- busy  out  1  high in every state except IDLE
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts the result
- out_data  out  ACC_W  signed result
- out_index  out  $clog2(N_PIX)  output position of out_data
- out_last  out  1  high with out_valid on the final result
- done_signal  out  1  one-cycle pulse at the end of a row
REQ-003 Illegal parameters (even KSIZE, KSIZE>7, KSIZE>N_PIX) SHALL stop elaboration with an error.

Function
REQ-004 The FSM SHALL have the states IDLE, LOAD, RUN, DONE.
- IDLE -> LOAD when start=1 (start sampled at edge T).
- LOAD -> RUN after one cycle.
- RUN -> DONE on the handshake of the out_last result.
- DONE -> IDLE after one cycle.
REQ-005 At the IDLE->LOAD transition the block SHALL capture the row, kernel, pad_mode and relu_en into internal registers; later input changes SHALL have no effect on the row in progress.
REQ-006 The output count SHALL be M = N_PIX-KSIZE+1 in VALID mode and M = N_PIX in SAME mode; indices SHALL be emitted 0..M-1 in order, each exactly once.
REQ-007 Output j SHALL equal sum over k=0..KSIZE-1 of w[k]*p[j+k-OFF], with OFF = 0 (VALID) or (KSIZE-1)/2 (SAME); pixel indices outside 0..N_PIX-1 SHALL read as 0.
REQ-008 Arithmetic:
- pixels are zero-extended to signed.
- products are full precision.
- the sum is ACC_W bits signed and SHALL never overflow.
- if relu_en=1, negative sums are replaced by 0.
REQ-009 The datapath SHALL be a two-stage pipeline: a registered tap-product stage, then an adder stage feeding the out_data register.
- The first out_valid SHALL occur at T+3.
- With out_ready held high, throughput SHALL be one result per cycle: the last result at T+2+M, and done_signal at T+3+M.
REQ-010 While out_valid=1 and out_ready=0, out_data, out_index and out_last SHALL hold stable, the whole pipeline SHALL stall, and no result SHALL be lost or duplicated.
REQ-011 out_valid SHALL deassert only after a handshake (out_valid & out_ready) and only when no further result is pending.
REQ-012 start SHALL be ignored while busy=1; start in the same cycle as the DONE state SHALL also be ignored.
REQ-013 done_signal SHALL be high exactly one cycle per completed row (in DONE) and never otherwise.

Reset
REQ-014 When rst_n=0 the block SHALL immediately (asynchronously) set state=IDLE, busy=0, out_valid=0, out_last=0, done_signal=0, out_data=0, out_index=0, and clear all pipeline, row and kernel registers.
REQ-015 A reset during LOAD or RUN SHALL abort the row with no done_signal.
- The first start after rst_n rises SHALL run normally from index 0.

Verification
REQ-016 Defaults, kernel {-1,2,-1}, p[i]=i, pad_mode=0, out_ready=1 -> exactly 30 results, all 0, indices 0..29, out_last on index 29, first out_valid at T+3, done_signal at T+33.
REQ-017 Same stimulus, pad_mode=1 -> 32 results: out[0]=-1, out[1..30]=0, out[31]=32; done_signal at T+35.
REQ-018 Impulse p[10]=255 (others 0), kernel {3,-5,7}, VALID -> out[8]=1785, out[9]=-1275, out[10]=765, all others 0; with relu_en=1 out[9]=0.
REQ-019 All pixels 255, kernel {-128,-128,-128}, VALID -> every result = -97920 (no wrap); with relu_en=1 every result = 0.
REQ-020 Backpressure: out_ready low for 5 cycles while index 3 is presented, then random 50% out_ready -> index-3 data stable throughout, full in-order sequence of 30 results, no duplicates; a start pulse issued mid-row is ignored.
REQ-021 Reset mid-row: rst_n low for 2 cycles while index 12 is valid -> out_valid, busy and done_signal go to 0 without waiting for a clock edge; a new start then produces indices from 0 with correct data.
